board_b_d_rom_arbiter: RTL and testbench

- Responder side of the per-layer graphics-ROM request interface used by the B-D background layers.
- Accepts toggle-handshake fetches from three playfield layers, each asking for a 32-bit tile-graphics word.
- Serves each fetch from a one-line per-port cache, or from SDRAM over a single 64-bit toggle-handshake channel.
- Sits between the three layer instances and the SDRAM controller port; runs entirely in the 32 MHz domain.

---
 rtl/board_b_d_rom_arbiter.sv | 163 ++++++++++++++++
 tb/tb_board_b_d_rom_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/board_b_d_rom_arbiter.sv
// Tile-ROM responder for the three B-D playfield layers: per-port one-line
// cache in front of a single round-robin 64-bit SDRAM toggle channel.
module board_b_d_rom_arbiter #(
    parameter logic [24:0] REGION_BASE = 25'h0,
    parameter bit          CACHE_EN    = 1'b1
) (
    input  logic        CLK_32M,
    input  logic        reset,
    input  logic        flush,
    input  logic [20:0] addr_a,
    input  logic [20:0] addr_b,
    input  logic [20:0] addr_c,
    input  logic        req_a,
    input  logic        req_b,
    input  logic        req_c,
    output logic [31:0] data_a,
    output logic [31:0] data_b,
    output logic [31:0] data_c,
    output logic        rdy_a,
    output logic        rdy_b,
    output logic        rdy_c,
    output logic [24:0] sdr_addr,
    output logic        sdr_req,
    input  logic [63:0] sdr_data,
    input  logic        sdr_rdy
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state_q;
    logic [1:0]  owner_q;
    logic [1:0]  ptr_q;
    logic [19:0] fetch_q;
    logic        sdr_req_q;
    logic [24:0] sdr_addr_q;
    logic [2:0]  rdy_q;
    logic [2:0]  valid_q;
    logic [31:0] data_q [3];
    logic [19:0] tag_q  [3];
    logic [63:0] line_q [3];

    logic [20:0] addr [3];
    logic [2:0]  req;
    logic [2:0]  pend;
    logic [2:0]  hit;
    logic [2:0]  miss;
    logic        gnt_vld_d;
    logic [1:0]  gnt_d;
    logic [1:0]  idx1;
    logic [1:0]  idx2;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [31:0] pick(input logic [63:0] l,
                                         input logic        s);
        return s ? l[63:32] : l[31:0];
    endfunction

    assign addr[0] = addr_a;
    assign addr[1] = addr_b;
    assign addr[2] = addr_c;
    assign req     = {req_c, req_b, req_a};

    // The fetch owner is excluded from hits so DONE is its only responder
    always_comb begin
        pend = '0;
        hit  = '0;
        miss = '0;
        for (int i = 0; i < 3; i++) begin
            pend[i] = req[i] ^ rdy_q[i];
            hit[i]  = CACHE_EN && pend[i] && valid_q[i]
                   && (tag_q[i] == addr[i][20:1])
                   && !(state_q != IDLE && owner_q == 2'(i));
            miss[i] = pend[i] && !hit[i];
        end
    end

    assign idx1 = nxt(ptr_q);
    assign idx2 = nxt(idx1);

    always_comb begin
        gnt_vld_d = 1'b1;
        gnt_d     = ptr_q;
        if (miss[ptr_q]) begin
            gnt_d = ptr_q;
        end else if (miss[idx1]) begin
            gnt_d = idx1;
        end else if (miss[idx2]) begin
            gnt_d = idx2;
        end else begin
            gnt_vld_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_32M) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= 2'd0;
            ptr_q      <= 2'd0;
            fetch_q    <= '0;
            sdr_req_q  <= 1'b0;
            sdr_addr_q <= '0;
            rdy_q      <= '0;
            valid_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
                line_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (hit[i]) begin
                    data_q[i] <= pick(line_q[i], addr[i][0]);
                    rdy_q[i]  <= ~rdy_q[i];
                end
            end
            if (flush) begin
                valid_q <= '0;
            end
            // Capture below overrides a same-cycle flush for the owner line
            unique case (state_q)
                IDLE: begin
                    if (gnt_vld_d) begin
                        owner_q    <= gnt_d;
                        fetch_q    <= addr[gnt_d][20:1];
                        sdr_addr_q <= REGION_BASE
                                    + {2'b00, addr[gnt_d][20:1], 3'b000};
                        sdr_req_q  <= ~sdr_req_q;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (sdr_rdy == sdr_req_q) begin
                        line_q[owner_q]  <= sdr_data;
                        tag_q[owner_q]   <= fetch_q;
                        valid_q[owner_q] <= CACHE_EN;
                        state_q          <= DONE;
                    end
                end
                DONE: begin
                    data_q[owner_q] <= pick(line_q[owner_q],
                                            addr[owner_q][0]);
                    rdy_q[owner_q]  <= ~rdy_q[owner_q];
                    ptr_q           <= nxt(owner_q);
                    state_q         <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_a   = data_q[0];
    assign data_b   = data_q[1];
    assign data_c   = data_q[2];
    assign rdy_a    = rdy_q[0];
    assign rdy_b    = rdy_q[1];
    assign rdy_c    = rdy_q[2];
    assign sdr_addr = sdr_addr_q;
    assign sdr_req  = sdr_req_q;

endmodule

// File: tb/tb_board_b_d_rom_arbiter.sv
// Directed bench for board_b_d_rom_arbiter: misses, hits, round-robin
// ordering, flush and mid-fetch reset against a toggle-handshake SDRAM model.
module tb_board_b_d_rom_arbiter;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [20:0] addr_a, addr_b, addr_c;
    logic        req_a, req_b, req_c;
    logic [31:0] data_a, data_b, data_c;
    logic        rdy_a, rdy_b, rdy_c;
    logic [24:0] sdr_addr;
    logic        sdr_req;
    logic [63:0] sdr_data;
    logic        sdr_rdy;

    int n_cmp = 0;
    int n_err = 0;

    board_b_d_rom_arbiter #(
        .REGION_BASE(25'h100000),
        .CACHE_EN   (1'b1)
    ) dut (
        .CLK_32M (clk),
        .reset   (reset),
        .flush   (flush),
        .addr_a  (addr_a),
        .addr_b  (addr_b),
        .addr_c  (addr_c),
        .req_a   (req_a),
        .req_b   (req_b),
        .req_c   (req_c),
        .data_a  (data_a),
        .data_b  (data_b),
        .data_c  (data_c),
        .rdy_a   (rdy_a),
        .rdy_b   (rdy_b),
        .rdy_c   (rdy_c),
        .sdr_addr(sdr_addr),
        .sdr_req (sdr_req),
        .sdr_data(sdr_data),
        .sdr_rdy (sdr_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a new SDRAM request, check its address, answer it
    task automatic serve(input string tag, input logic [24:0] ea,
                         input logic [63:0] d);
        int n;
        n = 0;
        while (sdr_req === sdr_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_grant"}, 64'(sdr_req !== sdr_rdy), 64'd1);
        chk({tag, "_addr"}, 64'(sdr_addr), 64'(ea));
        sdr_data = d;
        sdr_rdy  = sdr_req;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        flush    = 1'b0;
        addr_a   = '0;
        addr_b   = '0;
        addr_c   = '0;
        req_a    = 1'b0;
        req_b    = 1'b0;
        req_c    = 1'b0;
        sdr_data = '0;
        sdr_rdy  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_rdy", 64'({rdy_c, rdy_b, rdy_a}), 64'd0);
        chk("rst_data_a", 64'(data_a), 64'd0);
        chk("rst_data_b", 64'(data_b), 64'd0);
        chk("rst_data_c", 64'(data_c), 64'd0);
        chk("rst_sdr_req", 64'(sdr_req), 64'd0);
        chk("rst_sdr_addr", 64'(sdr_addr), 64'd0);

        // first miss on port a
        addr_a = 21'h000005;
        req_a  = 1'b1;
        @(negedge clk);
        chk("t1_sdr_req", 64'(sdr_req), 64'd1);
        chk("t1_sdr_addr", 64'(sdr_addr), 64'h100010);
        chk("t1_rdy_early", 64'(rdy_a), 64'd0);
        sdr_data = 64'h11112222_33334444;
        sdr_rdy  = 1'b1;
        @(negedge clk);
        chk("t1_rdy_cap", 64'(rdy_a), 64'd0);
        @(negedge clk);
        chk("t1_rdy", 64'(rdy_a), 64'd1);
        chk("t1_data", 64'(data_a), 64'h11112222);

        // hit on the same line, other word
        addr_a = 21'h000004;
        req_a  = 1'b0;
        @(negedge clk);
        chk("t2_rdy", 64'(rdy_a), 64'd0);
        chk("t2_data", 64'(data_a), 64'h33334444);
        chk("t2_no_sdr", 64'(sdr_req), 64'd1);

        // pointer back to a, then three simultaneous misses
        reset   = 1'b1;
        req_a   = 1'b0;
        req_b   = 1'b0;
        req_c   = 1'b0;
        sdr_rdy = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        addr_a = 21'h000010;
        addr_b = 21'h000020;
        addr_c = 21'h000031;
        req_a  = ~req_a;
        req_b  = ~req_b;
        req_c  = ~req_c;
        serve("t3_1a", 25'h100040, 64'hA0A0A0A0_A1A1A1A1);
        serve("t3_2b", 25'h100080, 64'hB0B0B0B0_B1B1B1B1);
        serve("t3_3c", 25'h1000C0, 64'hC0C0C0C0_C1C1C1C1);
        @(negedge clk);
        chk("t3_rdy", 64'({rdy_c, rdy_b, rdy_a}),
            64'({req_c, req_b, req_a}));
        chk("t3_data_a", 64'(data_a), 64'hA1A1A1A1);
        chk("t3_data_b", 64'(data_b), 64'hB1B1B1B1);
        chk("t3_data_c", 64'(data_c), 64'hC0C0C0C0);

        // one a miss moves the pointer to b
        addr_a = 21'h000040;
        req_a  = ~req_a;
        serve("t3_pre", 25'h100100, 64'hD0D0D0D0_D1D1D1D1);
        @(negedge clk);
        chk("t3_pre_data", 64'(data_a), 64'hD1D1D1D1);

        addr_a = 21'h000051;
        addr_b = 21'h000060;
        addr_c = 21'h000070;
        req_a  = ~req_a;
        req_b  = ~req_b;
        req_c  = ~req_c;
        serve("t3_4b", 25'h100180, 64'hB2B2B2B2_B3B3B3B3);
        serve("t3_5c", 25'h1001C0, 64'hC2C2C2C2_C3C3C3C3);
        serve("t3_6a", 25'h100140, 64'hA2A2A2A2_A3A3A3A3);
        @(negedge clk);
        chk("t3b_rdy", 64'({rdy_c, rdy_b, rdy_a}),
            64'({req_c, req_b, req_a}));
        chk("t3b_data_a", 64'(data_a), 64'hA2A2A2A2);
        chk("t3b_data_b", 64'(data_b), 64'hB3B3B3B3);
        chk("t3b_data_c", 64'(data_c), 64'hC3C3C3C3);

        // b hits while a waits on SDRAM
        addr_a = 21'h000080;
        req_a  = ~req_a;
        @(negedge clk);
        chk("t4_a_wait", 64'(sdr_req !== sdr_rdy), 64'd1);
        addr_b = 21'h000061;
        req_b  = ~req_b;
        @(negedge clk);
        chk("t4_rdy_b", 64'(rdy_b), 64'(req_b));
        chk("t4_data_b", 64'(data_b), 64'hB2B2B2B2);
        chk("t4_a_pend", 64'(rdy_a !== req_a), 64'd1);
        repeat (2) @(negedge clk);
        chk("t4_a_pend2", 64'(rdy_a !== req_a), 64'd1);
        serve("t4_a", 25'h100200, 64'hE0E0E0E0_E1E1E1E1);
        @(negedge clk);
        chk("t4_rdy_a", 64'(rdy_a), 64'(req_a));
        chk("t4_data_a", 64'(data_a), 64'hE1E1E1E1);

        // c hit, flush, then the same address misses
        addr_c = 21'h000071;
        req_c  = ~req_c;
        @(negedge clk);
        chk("t5_hit_rdy", 64'(rdy_c), 64'(req_c));
        chk("t5_hit_data", 64'(data_c), 64'hC2C2C2C2);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        req_c = ~req_c;
        @(negedge clk);
        chk("t5_miss_sdr", 64'(sdr_req !== sdr_rdy), 64'd1);
        chk("t5_miss_rdy", 64'(rdy_c !== req_c), 64'd1);
        serve("t5_refetch", 25'h1001C0, 64'hC4C4C4C4_C5C5C5C5);
        @(negedge clk);
        chk("t5_rdy", 64'(rdy_c), 64'(req_c));
        chk("t5_data", 64'(data_c), 64'hC4C4C4C4);

        // flush mid-WAIT and coincident with the capture
        addr_c = 21'h000100;
        req_c  = ~req_c;
        @(negedge clk);
        chk("t5w_addr", 64'(sdr_addr), 64'h100400);
        flush = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        sdr_data = 64'hF0F0F0F0_F1F1F1F1;
        sdr_rdy  = sdr_req;
        flush    = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        chk("t5w_rdy", 64'(rdy_c), 64'(req_c));
        chk("t5w_data", 64'(data_c), 64'hF1F1F1F1);
        addr_c = 21'h000101;
        req_c  = ~req_c;
        @(negedge clk);
        chk("t5w_hit_rdy", 64'(rdy_c), 64'(req_c));
        chk("t5w_hit_data", 64'(data_c), 64'hF0F0F0F0);
        chk("t5w_no_sdr", 64'(sdr_req === sdr_rdy), 64'd1);

        // reset during WAIT abandons the fetch
        addr_a = 21'h000090;
        req_a  = ~req_a;
        @(negedge clk);
        chk("t6_wait", 64'(sdr_req !== sdr_rdy), 64'd1);
        reset   = 1'b1;
        req_a   = 1'b0;
        req_b   = 1'b0;
        req_c   = 1'b0;
        sdr_rdy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_rdy", 64'({rdy_c, rdy_b, rdy_a}), 64'd0);
        chk("t6_data", 64'({data_a, data_b}), 64'd0);
        chk("t6_data_c", 64'(data_c), 64'd0);
        chk("t6_sdr", 64'({sdr_req, sdr_addr}), 64'd0);
        repeat (3) @(negedge clk);
        chk("t6_quiet", 64'({rdy_a, sdr_req}), 64'd0);
        addr_a = 21'h000005;
        req_a  = 1'b1;
        serve("t6_fresh", 25'h100010, 64'h11112222_33334444);
        @(negedge clk);
        chk("t6_fresh_rdy", 64'(rdy_a), 64'd1);
        chk("t6_fresh_data", 64'(data_a), 64'h11112222);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
